// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD parallel pixel link: frame geometry,
// counter widths and the error-bit layout of the receiver's frame report.
package lcd_pkg;

    // Nominal frame geometry
    localparam int LCD_LINES          = 1280;
    localparam int LCD_WORDS_PER_LINE = 40;
    localparam int LCD_LINE_GAP       = 4;
    localparam int LCD_UPDATE_LEN     = 48;
    localparam int LCD_BACK_PORCH     = 24;
    localparam int LCD_FRAME_CLOCKS   =
        LCD_LINES * (LCD_WORDS_PER_LINE + LCD_LINE_GAP) + LCD_BACK_PORCH;

    // Counter widths
    localparam int LCD_LEN_W       = 16;  // run/gap length meters
    localparam int LCD_LINE_W      = 11;  // line index / run count
    localparam int LCD_WORD_W      = 6;   // word index within a line
    localparam int LCD_FRAME_CNT_W = 17;  // clocks per frame

    // Frame error bits
    localparam int LCD_ERR_W          = 7;
    localparam int LCD_ERR_UPDATE_LEN = 0;
    localparam int LCD_ERR_RUN_LEN    = 1;
    localparam int LCD_ERR_LINE_GAP   = 2;
    localparam int LCD_ERR_RUN_COUNT  = 3;
    localparam int LCD_ERR_FRAME_LEN  = 4;
    localparam int LCD_ERR_POLARITY   = 5;
    localparam int LCD_ERR_DATA_IDLE  = 6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } lcd_rx_state_t;

endpackage

// File: rtl/lcd_run_meter.sv
// Measures high-run and low-gap lengths of a single strobe. Rise/fall are
// pulses in the cycle the new level is sampled; o_highLen is meaningful on
// o_fall (length of the run just ended), o_lowLen on o_rise (length of the
// gap just ended). Both counters saturate.
module lcd_run_meter
    import lcd_pkg::*;
#(
    parameter int CNT_W = LCD_LEN_W
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_level,
    output logic             o_rise,
    output logic             o_fall,
    output logic [CNT_W-1:0] o_highLen,
    output logic [CNT_W-1:0] o_lowLen
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_prev;
    logic [CNT_W-1:0] r_highCnt;
    logic [CNT_W-1:0] r_lowCnt;

    assign o_rise    = i_level & ~r_prev;
    assign o_fall    = ~i_level & r_prev;
    assign o_highLen = r_highCnt;
    assign o_lowLen  = r_lowCnt;

    // Track previous level and count the length of the current high or low stretch
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_prev    <= 1'b0;
            r_highCnt <= '0;
            r_lowCnt  <= '0;
        end else begin
            r_prev <= i_level;
            if (o_rise) begin
                r_highCnt <= CNT_W'(1);
            end else if (i_level && r_highCnt != CNT_MAX) begin
                r_highCnt <= r_highCnt + CNT_W'(1);
            end
            if (o_fall) begin
                r_lowCnt <= CNT_W'(1);
            end else if (!i_level && r_lowCnt != CNT_MAX) begin
                r_lowCnt <= r_lowCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/lcd_frame_rx.sv
// Panel-side receiver for the LCD parallel pixel interface. Recovers frame,
// line and word position from the strobes, re-emits accepted words with
// coordinates, sums them per frame and reports framing violations.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | not yet locked; waiting for the first update rise
//   ST_FRAME | locked; every update rise closes one frame and opens the next
module lcd_frame_rx
    import lcd_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int LINES          = LCD_LINES,
    parameter int WORDS_PER_LINE = LCD_WORDS_PER_LINE,
    parameter int LINE_GAP       = LCD_LINE_GAP,
    parameter int UPDATE_LEN     = LCD_UPDATE_LEN,
    parameter int BACK_PORCH     = LCD_BACK_PORCH
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_update,
    input  logic              i_invert,
    output logic [DATA_W-1:0] o_pixelData,
    output logic              o_pixelDV,
    output logic [10:0]       o_lineIndex,
    output logic [5:0]        o_wordIndex,
    output logic              o_locked,
    output logic              o_frameDone,
    output logic [31:0]       o_frameChecksum,
    output logic [10:0]       o_lineCount,
    output logic              o_framePolarity,
    output logic [6:0]        o_frameErr
);

    localparam int FRAME_CLOCKS = LINES * (WORDS_PER_LINE + LINE_GAP) + BACK_PORCH;
    localparam int PITCH_W      = LCD_LEN_W + 1;

    localparam logic [LCD_LEN_W-1:0]       RUN_REQ   = LCD_LEN_W'(WORDS_PER_LINE);
    localparam logic [LCD_LEN_W-1:0]       UPD_REQ   = LCD_LEN_W'(UPDATE_LEN);
    localparam logic [PITCH_W-1:0]         PITCH_REQ = PITCH_W'(WORDS_PER_LINE + LINE_GAP);
    localparam logic [LCD_LINE_W-1:0]      LINES_REQ = LCD_LINE_W'(LINES);
    localparam logic [LCD_FRAME_CNT_W-1:0] FRAME_REQ = LCD_FRAME_CNT_W'(FRAME_CLOCKS);
    localparam logic [LCD_WORD_W-1:0]      WORD_MAX  = LCD_WORD_W'(WORDS_PER_LINE - 1);
    localparam logic [LCD_LINE_W-1:0]      LINE_MAX  = '1;
    localparam logic [LCD_FRAME_CNT_W-1:0] CLK_MAX   = '1;

    lcd_rx_state_t r_state;
    lcd_rx_state_t w_stateNext;
    logic          w_publish;

    logic                 w_vRise, w_vFall, w_uRise, w_uFall;
    logic [LCD_LEN_W-1:0] w_vHigh, w_vLow, w_uHigh, w_uLow;

    logic [31:0]                r_sum;
    logic [LCD_LINE_W-1:0]      r_runCnt;
    logic [LCD_WORD_W-1:0]      r_wordPos;
    logic [LCD_FRAME_CNT_W-1:0] r_frameClk;
    logic [LCD_LEN_W-1:0]       r_lastRunLen;
    logic [LCD_ERR_W-1:0]       r_err;
    logic                       r_polarity;
    logic                       r_prevPol;
    logic                       r_polValid;

    logic                  w_accept;
    logic                  w_dataIdle;
    logic [LCD_LINE_W-1:0] w_lineNow;
    logic [LCD_WORD_W-1:0] w_wordNow;
    logic [LCD_LINE_W-1:0] w_runsNext;
    logic [PITCH_W-1:0]    w_pitch;
    logic [LCD_ERR_W-1:0]  w_errOld;
    logic [LCD_ERR_W-1:0]  w_errNew;
    logic [LCD_ERR_W-1:0]  w_errEnd;
    logic                  w_unusedUpdGap;

    lcd_run_meter #(.CNT_W(LCD_LEN_W)) u_valid_meter (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_level   (i_valid),
        .o_rise    (w_vRise),
        .o_fall    (w_vFall),
        .o_highLen (w_vHigh),
        .o_lowLen  (w_vLow)
    );

    lcd_run_meter #(.CNT_W(LCD_LEN_W)) u_update_meter (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_level   (i_update),
        .o_rise    (w_uRise),
        .o_fall    (w_uFall),
        .o_highLen (w_uHigh),
        .o_lowLen  (w_uLow)
    );

    // Update low time carries no framing rule of its own.
    assign w_unusedUpdGap = ^w_uLow;

    // A word sampled together with the update rise opens the new frame at line 0, word 0.
    assign w_accept   = i_valid && (r_state == ST_FRAME || w_uRise);
    assign w_dataIdle = !i_valid && (i_data != '0);
    assign w_lineNow  = w_uRise ? '0 : r_runCnt;
    assign w_wordNow  = w_uRise ? '0 : r_wordPos;
    assign w_runsNext = (w_vFall && r_runCnt != LINE_MAX) ? r_runCnt + LCD_LINE_W'(1) : r_runCnt;
    // Gap is judged against the line pitch so a short or long run, already
    // flagged as a run-length error, does not also count as a gap error.
    assign w_pitch    = {1'b0, r_lastRunLen} + {1'b0, w_vLow};

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state and publish decision
    always_comb begin
        w_stateNext = r_state;
        w_publish   = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_uRise) w_stateNext = ST_FRAME;
            ST_FRAME: if (w_uRise) w_publish = 1'b1;
        endcase
    end

    // Classify this cycle's violations: those closing the old frame versus those opening the new one
    always_comb begin
        w_errOld = '0;
        w_errOld[LCD_ERR_UPDATE_LEN] = w_uFall && (w_uHigh != UPD_REQ);
        w_errOld[LCD_ERR_RUN_LEN]    = w_vFall && (w_vHigh != RUN_REQ);
        w_errOld[LCD_ERR_LINE_GAP]   = w_vRise && !w_uRise && (r_runCnt != '0) && (w_pitch != PITCH_REQ);
        w_errOld[LCD_ERR_DATA_IDLE]  = !w_uRise && w_dataIdle;
        w_errNew = '0;
        w_errNew[LCD_ERR_DATA_IDLE]  = w_uRise && w_dataIdle;
        w_errEnd = '0;
        w_errEnd[LCD_ERR_RUN_COUNT]  = r_polarity ? (w_runsNext != LINES_REQ) : (w_runsNext != '0);
        w_errEnd[LCD_ERR_FRAME_LEN]  = (r_frameClk != FRAME_REQ);
        w_errEnd[LCD_ERR_POLARITY]   = r_polValid && (r_polarity == r_prevPol);
    end

    // Pixel re-emit, per-frame accumulation and frame report
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_pixelData     <= '0;
            o_pixelDV       <= 1'b0;
            o_lineIndex     <= '0;
            o_wordIndex     <= '0;
            o_locked        <= 1'b0;
            o_frameDone     <= 1'b0;
            o_frameChecksum <= '0;
            o_lineCount     <= '0;
            o_framePolarity <= 1'b0;
            o_frameErr      <= '0;
            r_sum           <= '0;
            r_runCnt        <= '0;
            r_wordPos       <= '0;
            r_frameClk      <= '0;
            r_lastRunLen    <= '0;
            r_err           <= '0;
            r_polarity      <= 1'b0;
            r_prevPol       <= 1'b0;
            r_polValid      <= 1'b0;
        end else begin
            o_pixelDV   <= w_accept;
            o_frameDone <= w_publish;
            if (w_accept) begin
                o_pixelData <= i_data;
                o_lineIndex <= w_lineNow;
                o_wordIndex <= w_wordNow;
                r_wordPos   <= (w_wordNow == WORD_MAX) ? w_wordNow : w_wordNow + LCD_WORD_W'(1);
            end else if (w_vFall) begin
                r_wordPos <= '0;
            end
            if (w_vFall) begin
                r_lastRunLen <= w_vHigh;
            end
            if (w_publish) begin
                o_frameChecksum <= r_sum;
                o_lineCount     <= w_runsNext;
                o_framePolarity <= r_polarity;
                o_frameErr      <= r_err | w_errOld | w_errEnd;
            end
            if (w_uRise) begin
                o_locked   <= 1'b1;
                r_sum      <= w_accept ? 32'(i_data) : 32'd0;
                r_runCnt   <= '0;
                r_frameClk <= LCD_FRAME_CNT_W'(1);
                r_err      <= w_errNew;
                r_polarity <= i_invert;
                r_prevPol  <= r_polarity;
                r_polValid <= (r_state == ST_FRAME);
            end else begin
                r_sum      <= r_sum + (w_accept ? 32'(i_data) : 32'd0);
                r_runCnt   <= w_runsNext;
                r_frameClk <= (r_frameClk == CLK_MAX) ? r_frameClk : r_frameClk + LCD_FRAME_CNT_W'(1);
                r_err      <= r_err | w_errOld;
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_rx.sv
// Directed bench for lcd_frame_rx using a reduced frame geometry
// (8 lines x 4 words, gap 2, update 5, porch 3 -> 51 clocks per frame).
module tb_lcd_frame_rx;

    localparam int NL    = 8;
    localparam int WPL   = 4;
    localparam int GAP   = 2;
    localparam int UPD   = 5;
    localparam int BP    = 3;
    localparam int PITCH = WPL + GAP;
    localparam int FLEN  = NL * PITCH + BP;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] i_data  = '0;
    logic        i_valid = 1'b0;
    logic        i_update = 1'b0;
    logic        i_invert = 1'b0;
    logic [31:0] o_pixelData;
    logic        o_pixelDV;
    logic [10:0] o_lineIndex;
    logic [5:0]  o_wordIndex;
    logic        o_locked;
    logic        o_frameDone;
    logic [31:0] o_frameChecksum;
    logic [10:0] o_lineCount;
    logic        o_framePolarity;
    logic [6:0]  o_frameErr;

    int n_total = 0;
    int n_bad   = 0;

    lcd_frame_rx #(
        .DATA_W(32), .LINES(NL), .WORDS_PER_LINE(WPL),
        .LINE_GAP(GAP), .UPDATE_LEN(UPD), .BACK_PORCH(BP)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
        .i_update(i_update), .i_invert(i_invert),
        .o_pixelData(o_pixelData), .o_pixelDV(o_pixelDV),
        .o_lineIndex(o_lineIndex), .o_wordIndex(o_wordIndex),
        .o_locked(o_locked), .o_frameDone(o_frameDone),
        .o_frameChecksum(o_frameChecksum), .o_lineCount(o_lineCount),
        .o_framePolarity(o_framePolarity), .o_frameErr(o_frameErr)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // One frame starting with an update rise; outputs are checked 1 clock after each sample.
    task automatic send_frame(input bit pol, input logic [31:0] w, input int upd_len,
                              input int short_line, input int junk_c, input int len,
                              input bit exp_done);
        for (int c = 0; c < len; c++) begin
            int k;
            int p;
            int rl;
            bit v;
            k  = c / PITCH;
            p  = c % PITCH;
            rl = (k == short_line) ? WPL - 1 : WPL;
            v  = pol && (k < NL) && (p < rl);
            i_update = (c < upd_len);
            i_invert = pol;
            i_valid  = v;
            i_data   = v ? w : ((c == junk_c) ? 32'h5 : 32'h0);
            tick();
            if (c == 0) begin
                chk("frame_done", {31'b0, o_frameDone}, {31'b0, exp_done});
                chk("locked", {31'b0, o_locked}, 32'd1);
            end else begin
                chk("done_pulse", {31'b0, o_frameDone}, 32'd0);
            end
            chk("pix_dv", {31'b0, o_pixelDV}, {31'b0, v});
            if (v) begin
                chk("pix_data", o_pixelData, w);
                chk("pix_line", {21'b0, o_lineIndex}, k);
                chk("pix_word", {26'b0, o_wordIndex}, p);
            end
        end
    endtask

    task automatic check_pub(input string tag, input logic [31:0] sum, input int lines,
                             input bit pol, input logic [6:0] err);
        chk({tag, "_sum"}, o_frameChecksum, sum);
        chk({tag, "_lines"}, {21'b0, o_lineCount}, lines);
        chk({tag, "_pol"}, {31'b0, o_framePolarity}, {31'b0, pol});
        chk({tag, "_err"}, {25'b0, o_frameErr}, {25'b0, err});
    endtask

    task automatic do_reset();
        i_reset  = 1'b1;
        i_update = 1'b0;
        i_valid  = 1'b0;
        i_data   = '0;
        i_invert = 1'b0;
        tick();
        tick();
        chk("rst_locked", {31'b0, o_locked}, 32'd0);
        chk("rst_done", {31'b0, o_frameDone}, 32'd0);
        chk("rst_dv", {31'b0, o_pixelDV}, 32'd0);
        chk("rst_sum", o_frameChecksum, 32'd0);
        chk("rst_lines", {21'b0, o_lineCount}, 32'd0);
        chk("rst_err", {25'b0, o_frameErr}, 32'd0);
        i_reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("idle_done", {31'b0, o_frameDone}, 32'd0);
            chk("idle_locked", {31'b0, o_locked}, 32'd0);
        end
    endtask

    initial begin
        do_reset();

        // F1 nominal data frame (lock), F2 blank
        send_frame(1'b1, 32'hFFFF_FFFF, UPD, -1, -1, FLEN, 1'b0);
        send_frame(1'b0, 32'h0, UPD, -1, -1, FLEN, 1'b1);
        check_pub("f1", 32'hFFFF_FFE0, NL, 1'b1, 7'h00);

        // F3 data frame with a short run on line 2 and a lengthened gap
        send_frame(1'b1, 32'h0101_0101, UPD, 2, -1, FLEN, 1'b1);
        check_pub("f2", 32'h0, 0, 1'b0, 7'h00);

        // F4 blank frame with update held one clock short
        send_frame(1'b0, 32'h0, UPD - 1, -1, -1, FLEN, 1'b1);
        check_pub("f3", 32'h1F1F_1F1F, NL, 1'b1, 7'h02);

        // F5 data frame with nonzero data in a gap clock
        send_frame(1'b1, 32'hFFFF_FFFF, UPD, -1, 4, FLEN, 1'b1);
        check_pub("f4", 32'h0, 0, 1'b0, 7'h01);

        // F6 repeats polarity 1 and is cut short by an early update rise
        send_frame(1'b1, 32'hFFFF_FFFF, UPD, -1, -1, 23, 1'b1);
        check_pub("f5", 32'hFFFF_FFE0, NL, 1'b1, 7'h40);

        // F7 full blank frame counted from the early rise
        send_frame(1'b0, 32'h0, UPD, -1, -1, FLEN, 1'b1);
        check_pub("f6", 32'hFFFF_FFF0, 4, 1'b1, 7'h38);

        // F8 aborted by reset part way through
        send_frame(1'b1, 32'hFFFF_FFFF, UPD, -1, -1, 30, 1'b1);
        check_pub("f7", 32'h0, 0, 1'b0, 7'h00);
        do_reset();

        // Two good frames after reset, then a closing rise
        send_frame(1'b1, 32'hFFFF_FFFF, UPD, -1, -1, FLEN, 1'b0);
        send_frame(1'b0, 32'h0, UPD, -1, -1, FLEN, 1'b1);
        check_pub("f9", 32'hFFFF_FFE0, NL, 1'b1, 7'h00);
        send_frame(1'b1, 32'hFFFF_FFFF, UPD, -1, -1, 1, 1'b1);
        check_pub("f10", 32'h0, 0, 1'b0, 7'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
